e1_rx_liu_mc: RTL and testbench
===============================

E1_RX_LIU_MC -- requirements
Module: e1_rx_liu_mc

Interface
REQ-001 Parameter N_CH, default 1: number of independent LIU receive channels (1..8).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per pad input (2..4).
REQ-003 Parameter LOC_TIMEOUT, default 64: clk cycles without an accepted edge before loss-of-clock is flagged (2..4095).
REQ-004 Parameter LOC_W, default 12: loss-of-clock counter width; LOC_TIMEOUT SHALL be less than 2**LOC_W.
REQ-005 clk  input  1  single system clock; all logic is in this domain.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 pad_rx_data  input  N_CH  per-channel recovered data from the external LIU, asynchronous.
REQ-008 pad_rx_clk  input  N_CH  per-channel recovered clock from the external LIU, asynchronous.
REQ-009 cfg_edge  input  N_CH  per channel: 0 = strobe on pad clock falling edge, 1 = strobe on rising edge; quasi-static.
REQ-010 out_data  output  N_CH  per-channel data bit, meaningful only while the matching out_valid bit is 1.
REQ-011 out_valid  output  N_CH  per-channel one-cycle strobe, one per accepted pad clock edge.
REQ-012 out_loc  output  N_CH  per-channel loss-of-clock flag, level.

Function
REQ-013 Each channel SHALL pass pad_rx_data and pad_rx_clk through SYNC_STAGES flip-flops, with equal depth on both paths.
REQ-014 An edge SHALL be accepted when the last synchronised clock sample differs from the previous sample in the direction selected by cfg_edge.
REQ-015 out_valid SHALL be registered: high for exactly one cycle, SYNC_STAGES+1 cycles after the cycle in which the active clock transition is first sampled.
REQ-016 out_data SHALL equal the data level sampled in the same cycle as the clock sample that completed the accepted edge.
REQ-017 Consecutive accepted edges SHALL be at least two cycles apart; out_valid SHALL never be high in two adjacent cycles for one channel.
REQ-018 Each channel SHALL keep a saturating counter that clears to 0 on every accepted edge and otherwise increments each cycle.
REQ-019 out_loc SHALL rise in the cycle after the counter reaches LOC_TIMEOUT and stay high until the next accepted edge.
REQ-020 An accepted edge SHALL clear out_loc in the same cycle that out_valid is asserted.
REQ-021 The counter SHALL stop at LOC_TIMEOUT and SHALL NOT wrap.
REQ-022 A change of cfg_edge SHALL take effect at the next sample comparison; it SHALL NOT produce a spurious strobe on its own.
REQ-023 Channels SHALL be fully independent; simultaneous edges on any set of channels SHALL all be strobed in the same cycle.

Reset
REQ-024 While rst_n is low: all synchroniser stages at 0; out_data, out_valid and out_loc at 0; counters at 0.
REQ-025 After rst_n deasserts, the first edge SHALL NOT be accepted until all SYNC_STAGES stages hold real pad samples (SYNC_STAGES+1 cycles).
REQ-026 Reset asserted mid-stream SHALL drop any in-flight strobe immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro E1_RX_LIU_GLITCH_FILTER_EN defined: a clock level change SHALL be accepted only after two consecutive identical synchronised samples, adding exactly one cycle of latency to out_valid and out_data.
REQ-028 Macro undefined: no filter, and latency is as stated in REQ-015.

Structure
REQ-029 The shared package e1_rx_pkg SHALL hold the default LOC_TIMEOUT and LOC_W constants and the edge-select encoding (EDGE_FALL=0, EDGE_RISE=1).
REQ-030 The per-channel logic SHALL be the sub-module e1_rx_liu_ch, instantiated N_CH times by a generate loop; the top level SHALL contain no other logic.

Verification
REQ-031 N_CH=1, SYNC_STAGES=2, cfg_edge=0, pad clock 8 cycles high / 8 low, data alternating 1,0 -> out_valid one cycle wide every 16 cycles, 3 cycles after each falling sample; out_data 1,0,1,...
REQ-032 Same stimulus with cfg_edge=1 -> strobes move to the rising edges; data values are captured at the rising sample points.
REQ-033 LOC_TIMEOUT=10, pad clock held low -> out_loc rises after 10 edge-free cycles; the next falling edge clears out_loc in the same cycle out_valid pulses.
REQ-034 N_CH=4, identical edges on channels 0 and 3, channel 2 idle -> out_valid=4'b1001 in one cycle; channel 2 out_loc asserts independently.
REQ-035 Filter enabled, one-cycle high glitch on pad clock -> no strobe; a clean edge -> strobe at latency SYNC_STAGES+2.
REQ-036 rst_n pulsed low while a strobe is in flight -> out_valid stays 0 and all outputs read 0 during reset; after release no strobe within SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/e1_rx_pkg.sv
// Shared constants for the E1 LIU receive front end: default loss-of-clock
// settings and the per-channel edge-select encoding.
package e1_rx_pkg;

  localparam int LOC_TIMEOUT_DEF = 64;
  localparam int LOC_W_DEF       = 12;

  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_sel_e;

endpackage

// File: rtl/e1_rx_liu_ch.sv
// One LIU receive channel: pad synchronisers, edge detect, data strobe and
// loss-of-clock watchdog. Optional glitch filter: E1_RX_LIU_GLITCH_FILTER_EN.
module e1_rx_liu_ch
  import e1_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOC_TIMEOUT = LOC_TIMEOUT_DEF,
  parameter int LOC_W       = LOC_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_rx_data,
  input  logic pad_rx_clk,
  input  logic cfg_edge,
  output logic out_data,
  output logic out_valid,
  output logic out_loc
);

`ifdef E1_RX_LIU_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  // Edges are ignored until every history register holds a genuine pad sample.
  localparam int ARM_W = SYNC_STAGES + 2 + FILT;
  localparam logic [LOC_W-1:0] LOC_LIM = LOC_W'(LOC_TIMEOUT);

  function automatic logic [LOC_W-1:0] sat_inc(input logic [LOC_W-1:0] v);
    return (v >= LOC_LIM) ? LOC_LIM : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_p0;
  logic                   dat_p0;
  logic                   lvl;
  logic [ARM_W-1:0]       arm;
  logic [LOC_W-1:0]       loc_cnt;
  logic                   clk_ok;
  logic                   dir_ok;
  logic                   acc;

  // Stage p0: synchroniser output and history, equal depth for clock and data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_p0   <= 1'b0;
      dat_p0   <= 1'b0;
      lvl      <= 1'b0;
      arm      <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], pad_rx_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], pad_rx_data};
      clk_p0   <= clk_sync[SYNC_STAGES-1];
      dat_p0   <= dat_sync[SYNC_STAGES-1];
      arm      <= {arm[ARM_W-2:0], 1'b1};
      if (clk_ok) lvl <= clk_p0;
    end
  end

`ifdef E1_RX_LIU_GLITCH_FILTER_EN
  // A new level counts only once two consecutive samples agree.
  logic clk_p1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_p1 <= 1'b0;
    else        clk_p1 <= clk_p0;
  end
  assign clk_ok = (clk_p0 == clk_p1);
`else
  assign clk_ok = 1'b1;
`endif

  assign dir_ok = (edge_sel_e'(cfg_edge) == EDGE_RISE) ? clk_p0 : ~clk_p0;
  assign acc    = arm[ARM_W-1] & clk_ok & (clk_p0 != lvl) & dir_ok & ~out_valid;

  // Stage p1: registered strobe, data and loss-of-clock watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_loc   <= 1'b0;
      loc_cnt   <= '0;
    end else begin
      out_valid <= acc;
      out_data  <= dat_p0;
      loc_cnt   <= acc ? '0 : sat_inc(loc_cnt);
      out_loc   <= acc ? 1'b0 : (out_loc | (loc_cnt == LOC_LIM));
    end
  end

endmodule

// File: rtl/e1_rx_liu_mc.sv
// Multi-channel E1 LIU receive front end: N_CH independent e1_rx_liu_ch
// channels. Optional glitch filter: E1_RX_LIU_GLITCH_FILTER_EN.
module e1_rx_liu_mc
  import e1_rx_pkg::*;
#(
  parameter int N_CH        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int LOC_TIMEOUT = LOC_TIMEOUT_DEF,
  parameter int LOC_W       = LOC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pad_rx_data,
  input  logic [N_CH-1:0] pad_rx_clk,
  input  logic [N_CH-1:0] cfg_edge,
  output logic [N_CH-1:0] out_data,
  output logic [N_CH-1:0] out_valid,
  output logic [N_CH-1:0] out_loc
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    e1_rx_liu_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .LOC_TIMEOUT (LOC_TIMEOUT),
      .LOC_W       (LOC_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .pad_rx_data (pad_rx_data[i]),
      .pad_rx_clk  (pad_rx_clk[i]),
      .cfg_edge    (cfg_edge[i]),
      .out_data    (out_data[i]),
      .out_valid   (out_valid[i]),
      .out_loc     (out_loc[i])
    );
  end

endmodule

// File: tb/tb_e1_rx_liu_mc.sv
// Directed bench for e1_rx_liu_mc with a per-channel strobe scoreboard and a
// cycle-level loss-of-clock expectation.
module tb_e1_rx_liu_mc;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int LOC  = 10;
`ifdef E1_RX_LIU_GLITCH_FILTER_EN
  localparam int LAT  = SYNC + 2;
`else
  localparam int LAT  = SYNC + 1;
`endif

  typedef struct {
    int   due;
    logic d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pad_rx_data;
  logic [N-1:0] pad_rx_clk;
  logic [N-1:0] cfg_edge;
  logic [N-1:0] out_data;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_loc;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_v [N];
  exp_t sb [N][$];
  logic [N-1:0] dpat;

  e1_rx_liu_mc #(
    .N_CH        (N),
    .SYNC_STAGES (SYNC),
    .LOC_TIMEOUT (LOC),
    .LOC_W       (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_rx_data (pad_rx_data),
    .pad_rx_clk  (pad_rx_clk),
    .cfg_edge    (cfg_edge),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_loc     (out_loc)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check();
    logic [N-1:0] ev, ed, el;
    ev = '0; ed = '0; el = '0;
    if (!rst_n) begin
      total++;
      assert ({out_valid, out_data, out_loc} === '0) else begin
        bad++;
        $error("FAIL reset_outs got v=%b d=%b l=%b exp all 0", out_valid, out_data, out_loc);
      end
      return;
    end
    for (int c = 0; c < N; c++) begin
      if (sb[c].size() > 0 && sb[c][0].due == cyc) begin
        ev[c] = 1'b1;
        ed[c] = sb[c][0].d;
        void'(sb[c].pop_front());
      end
      el[c] = ((cyc - last_v[c]) > LOC) && !ev[c];
      if (ev[c]) last_v[c] = cyc;
    end
    total++;
    assert (out_valid === ev) else begin
      bad++;
      $error("FAIL valid_vec cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
    end
    if (ev != '0) begin
      total++;
      assert ((out_data & ev) === ed) else begin
        bad++;
        $error("FAIL data_vec cyc=%0d got=%b exp=%b", cyc, out_data & ev, ed);
      end
    end
    total++;
    assert (out_loc === el) else begin
      bad++;
      $error("FAIL loc_vec cyc=%0d got=%b exp=%b", cyc, out_loc, el);
    end
  endtask

  task automatic step(input logic [N-1:0] ck, input logic [N-1:0] dt, input bit push);
    @(negedge clk);
    check();
    for (int c = 0; c < N; c++)
      if (push && ck[c] != pad_rx_clk[c] && ck[c] == cfg_edge[c])
        sb[c].push_back('{due: cyc + LAT + 1, d: dt[c]});
    pad_rx_clk  = ck;
    pad_rx_data = dt;
  endtask

  task automatic period(input logic [N-1:0] m);
    step(m, dpat, 1'b1);
    repeat (7) step(m, dpat, 1'b1);
    dpat = dpat ^ m;
    step('0, dpat, 1'b1);
    repeat (7) step('0, dpat, 1'b1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    check();
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) last_v[c] = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    pad_rx_clk = '0;
    pad_rx_data = '0;
    cfg_edge = '0;
    dpat = '0;
    for (int c = 0; c < N; c++) last_v[c] = 0;

    repeat (3) step('0, '0, 1'b1);
    release_rst();
    repeat (8) step('0, dpat, 1'b1);

    // falling-edge strobes, data 1,0,1
    repeat (3) period(4'b0001);

    // rising-edge strobes
    cfg_edge = '1;
    repeat (2) period(4'b0001);

    // loss of clock with clock held low, then a falling edge clears it
    cfg_edge = '0;
    repeat (20) step('0, dpat, 1'b1);
    total++;
    assert (out_loc[0] === 1'b1) else begin
      bad++;
      $error("FAIL loc_held_low got=%b exp=1", out_loc[0]);
    end
    period(4'b0001);

`ifdef E1_RX_LIU_GLITCH_FILTER_EN
    // single-cycle glitch must be rejected
    step(4'b0001, dpat, 1'b0);
    step('0, dpat, 1'b0);
    repeat (10) step('0, dpat, 1'b1);
    period(4'b0001);
`endif

    // simultaneous edges on channels 0 and 3, channel 2 idle
    repeat (2) period(4'b1001);
    total++;
    assert (out_loc[2] === 1'b1) else begin
      bad++;
      $error("FAIL loc_ch2_idle got=%b exp=1", out_loc[2]);
    end

    // reset while a strobe is in flight
    cfg_edge = '1;
    repeat (4) step('0, dpat, 1'b1);
    step(4'b0001, dpat, 1'b1);
    @(negedge clk);
    check();
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) sb[c].delete();
    #1;
    total++;
    assert ({out_valid, out_data, out_loc} === '0) else begin
      bad++;
      $error("FAIL async_reset got v=%b d=%b l=%b exp all 0", out_valid, out_data, out_loc);
    end
    repeat (3) step(4'b0001, dpat, 1'b1);
    release_rst();
    repeat (SYNC + 6) step(4'b0001, dpat, 1'b1);
    period(4'b0001);
    repeat (4) step('0, dpat, 1'b1);

    total++;
    assert ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) === 0) else begin
      bad++;
      $error("FAIL sb_drain got=%0d exp=0", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
